// File: rtl/seq_divider.sv
// Iterative signed divider: restoring division, one quotient bit per cycle, valid/ready on both sides.
// Optional bypass for zero operands is built when SEQ_DIVIDER_EARLY_OUT_EN is defined.
module seq_divider #(
  parameter int DATAW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DATAW-1:0] i_dataa,
  input  logic [DATAW-1:0] i_datab,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DATAW-1:0] o_quotient,
  output logic [DATAW-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic             o_overflow
);

  localparam int CW = $clog2(DATAW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [DATAW-1:0] dvd_q;    // |a| shifting out MSB-first, quotient bits shifting in at LSB
  logic [DATAW-1:0] absb_q;
  logic [DATAW-1:0] rem_q;
  logic [DATAW-1:0] a_q;
  logic [CW-1:0]    cnt_q;
  logic             nega_q, negq_q, dz_q, ov_q;
  logic             ready_q, valid_q, dz_o_q, ov_o_q;
  logic [DATAW-1:0] quo_o_q, rem_o_q;

  logic             a_neg, b_neg, early;
  logic [DATAW-1:0] abs_a, abs_b;
  logic [DATAW:0]   shift_d, trial_d;
  logic [DATAW-1:0] rem_d, dvd_d, quo_fin_d, rem_fin_d;

  assign a_neg = i_dataa[DATAW-1];
  assign b_neg = i_datab[DATAW-1];
  assign abs_a = a_neg ? (-i_dataa) : i_dataa;
  assign abs_b = b_neg ? (-i_datab) : i_datab;

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  assign early = (i_datab == '0) || (i_dataa == '0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    shift_d = {rem_q, dvd_q[DATAW-1]};
    trial_d = shift_d - {1'b0, absb_q};
    rem_d   = trial_d[DATAW] ? shift_d[DATAW-1:0] : trial_d[DATAW-1:0];
    dvd_d   = {dvd_q[DATAW-2:0], ~trial_d[DATAW]};
    quo_fin_d = dz_q ? '1 : (negq_q ? (-dvd_q) : dvd_q);
    rem_fin_d = dz_q ? a_q : (nega_q ? (-rem_q) : rem_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      absb_q  <= '0;
      rem_q   <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      nega_q  <= 1'b0;
      negq_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      quo_o_q <= '0;
      rem_o_q <= '0;
      dz_o_q  <= 1'b0;
      ov_o_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          dvd_q   <= abs_a;
          absb_q  <= abs_b;
          rem_q   <= '0;
          a_q     <= i_dataa;
          nega_q  <= a_neg;
          negq_q  <= a_neg ^ b_neg;
          dz_q    <= (i_datab == '0);
          ov_q    <= (i_dataa == {1'b1, {(DATAW-1){1'b0}}}) && (i_datab == '1);
          // A zero operand already holds its final q/r, so zero iterations are needed
          cnt_q   <= early ? '0 : CW'(DATAW);
          ready_q <= 1'b0;
          state_q <= CALC;
        end
        CALC: if (cnt_q != '0) begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - 1'b1;
        end else begin
          quo_o_q <= quo_fin_d;
          rem_o_q <= rem_fin_d;
          dz_o_q  <= dz_q;
          ov_o_q  <= ov_q;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (i_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = valid_q;
  assign o_quotient    = quo_o_q;
  assign o_remainder   = rem_o_q;
  assign o_div_by_zero = dz_o_q;
  assign o_overflow    = ov_o_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (DATAW=8): directed vector table, back-pressure and mid-op reset sequences,
// and random operands checked against an integer-arithmetic reference.
module tb_seq_divider;

  logic       i_clk = 1'b0;
  logic       i_rst, i_valid, i_ready;
  logic [7:0] i_dataa, i_datab;
  logic       o_ready, o_valid, o_div_by_zero, o_overflow;
  logic [7:0] o_quotient, o_remainder;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  seq_divider #(.DATAW(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_dataa(i_dataa), .i_datab(i_datab), .o_valid(o_valid), .i_ready(i_ready),
    .o_quotient(o_quotient), .o_remainder(o_remainder),
    .o_div_by_zero(o_div_by_zero), .o_overflow(o_overflow)
  );

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       dz, ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: plain signed integer arithmetic plus the two special cases.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dz, output logic ov);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = (sb == 0);
    ov = (sa == -128) && (sb == -1);
    if (dz) begin
      q = 8'hFF; r = a;
    end else if (ov) begin
      q = 8'h80; r = 8'h00;
    end else begin
      q = 8'(sa / sb); r = 8'(sa % sb);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
    int l;
    l = 9;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    if (a == 8'h00 || b == 8'h00) l = 1;
`endif
    return l;
  endfunction

  // Issues one op from an idle DUT, checks latency and result, applies bp cycles of back-pressure.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input logic eov, input int bp);
    int lat;
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_dataa = a; i_datab = b;
    step();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(a, b)));
    chk({tag, "_q"}, 32'(o_quotient), 32'(eq));
    chk({tag, "_r"}, 32'(o_remainder), 32'(er));
    chk({tag, "_dz"}, 32'(o_div_by_zero), 32'(edz));
    chk({tag, "_ov"}, 32'(o_overflow), 32'(eov));
    for (int k = 0; k < bp; k++) begin
      step();
      chk({tag, "_hold_q"}, {o_valid, o_ready, o_remainder, o_quotient}, {1'b1, 1'b0, er, eq});
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk({tag, "_drop"}, {o_valid, o_ready}, 32'b01);
  endtask

  vec_t tbl[11];

  initial begin
    logic [7:0] ra, rb, mq, mr;
    logic       mdz, mov;
    logic       stray;

    tbl[0]  = '{8'd100,  8'd7,    8'h0E, 8'h02, 1'b0, 1'b0};
    tbl[1]  = '{8'h9C,   8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0};
    tbl[2]  = '{8'd7,    8'h9C,   8'h00, 8'h07, 1'b0, 1'b0};
    tbl[3]  = '{8'hF9,   8'hFE,   8'h03, 8'hFF, 1'b0, 1'b0};
    tbl[4]  = '{8'h80,   8'hFF,   8'h80, 8'h00, 1'b0, 1'b1};
    tbl[5]  = '{8'd5,    8'h00,   8'hFF, 8'h05, 1'b1, 1'b0};
    tbl[6]  = '{8'h00,   8'd5,    8'h00, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{8'h80,   8'h01,   8'h80, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{8'h7F,   8'h80,   8'h00, 8'h7F, 1'b0, 1'b0};
    tbl[9]  = '{8'h80,   8'h80,   8'h01, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{8'hFF,   8'h00,   8'hFF, 8'hFF, 1'b1, 1'b0};

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_dataa = '0; i_datab = '0;
    step();
    chk("rst_ready_in_reset", 32'(o_ready), 32'd1);
    step();
    i_rst = 1'b0;
    chk("rst_state", {o_ready, o_valid, o_div_by_zero, o_overflow, o_remainder, o_quotient},
        {4'b1000, 8'h00, 8'h00});

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
             tbl[i].dz, tbl[i].ov, 0);

    // Back-pressure: result held 5 cycles while a stray request is presented.
    i_valid = 1'b1; i_dataa = 8'd100; i_datab = 8'd7;
    step();
    i_dataa = 8'd1; i_datab = 8'd1;
    for (int k = 0; k < 40 && !o_valid; k++) step();
    chk("bp_valid", 32'(o_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold", {o_valid, o_ready, o_remainder, o_quotient}, {2'b10, 8'h02, 8'h0E});
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0; i_valid = 1'b0;
    chk("bp_handshake", {o_valid, o_ready}, 32'b01);
    step();
    chk("bp_no_accept", {o_valid, o_ready}, 32'b01);

    // Reset four cycles into CALC, with a competing request during reset.
    i_valid = 1'b1; i_dataa = 8'd77; i_datab = 8'd3;
    step();
    i_valid = 1'b0;
    repeat (4) step();
    i_rst = 1'b1; i_valid = 1'b1; i_dataa = 8'd1; i_datab = 8'd1;
    step();
    i_rst = 1'b0; i_valid = 1'b0;
    chk("rstmid_state", {o_ready, o_valid, o_remainder, o_quotient}, {2'b10, 8'h00, 8'h00});
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (o_valid || !o_ready) stray = 1'b1;
    end
    chk("rstmid_quiet", 32'(stray), 32'd0);
    run_op("after_rst", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 100; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 19) == 0) begin ra = 8'h80; rb = 8'hFF; end
      if ($urandom_range(0, 19) == 0) ra = 8'h00;
      model(ra, rb, mq, mr, mdz, mov);
      run_op($sformatf("rnd%0d_%0h_%0h", n, ra, rb), ra, rb, mq, mr, mdz, mov,
             $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
